writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Write-side producer for the register file: merges ALU results and load responses onto the single write port.
//  - Drives reg_write, rd and rd_data; performs load byte/half extraction and sign/zero extension.
//  - Keeps a load scoreboard that stalls decode on RAW hazards against loads still in flight.
//  - Sits between execute/memory and the register file.
// PARAMETERS
//  XLEN   32  datapath width
//  NREG   32  architectural registers; index width is $clog2(NREG)=5
//  CNT_W  64  retire counter width (used only when WB_RETIRE_CNT_EN is defined)
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     asynchronous reset, active-high
//  alu_valid     in   1     ALU result offered
//  alu_ready     out  1     ALU result accepted this cycle when alu_valid && alu_ready
//  alu_we        in   1     instruction writes rd; 0 retires it without a write
//  alu_rd        in   5     ALU destination
//  alu_data      in   XLEN  ALU result
//  ld_issue      in   1     load issued to memory this cycle
//  ld_issue_rd   in   5     destination of the issued load
//  mem_rvalid    in   1     load response; always accepted, no backpressure
//  mem_rd        in   5     load destination
//  mem_rdata     in   XLEN  raw aligned memory word
//  mem_funct3    in   3     000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  mem_addr_lo   in   2     byte offset of the load address
//  rs1_q, rs2_q  in   5     decode source registers for the hazard check
//  hazard_stall  out  1     combinational: busy[rs1_q] | busy[rs2_q]
//  reg_write     out  1     registered write enable to the register file
//  rd            out  5     registered write index
//  rd_data       out  XLEN  registered write data
//  retire_count  out  CNT_W retired instructions (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset: reg_write=0, rd=0, rd_data=0, pending buffer EMPTY, all busy bits 0, retire_count=0.
//    An asserted rst mid-operation drops any held result.
//  - Latency: an accepted source appears on reg_write/rd/rd_data on the next rising edge, held for 1 cycle.
//  - Arbitration priority per cycle: mem_rvalid > HELD buffer > live ALU input.
//  - Pending buffer FSM (one entry):
//    - EMPTY -> HELD when the ALU handshakes in the same cycle as mem_rvalid.
//    - HELD -> EMPTY when written back in a cycle with no mem_rvalid.
//    - alu_ready = (state==EMPTY).
//    - A new ALU handshake cannot occur in the cycle HELD drains, because alu_ready=0.
//  - Load extract:
//    - LB/LBU: byte mem_addr_lo.
//    - LH/LHU: half mem_addr_lo[1]; mem_addr_lo[0] is ignored.
//    - LW: the whole word.
//    - Sign-extend LB/LH; zero-extend LBU/LHU.
//    - Any other funct3: data 0; the write still occurs.
//  - rd==0 (or alu_we=0): reg_write=0 in the output cycle, rd_data=0; the instruction is still retired.
//  - Scoreboard:
//    - Set busy[ld_issue_rd] on ld_issue when the index is non-zero.
//    - Clear busy[mem_rd] on mem_rvalid.
//    - Same index set and cleared in one cycle: set wins.
//    - busy[0] is constant 0.
//    - One outstanding load per rd is assumed by the issue stage.
//  - The write port is registered, so the register file's write-through bypass covers the write cycle.
//    hazard_stall deasserts in the cycle after mem_rvalid.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined:
//   - retire_count increments by 1 per output retire cycle, including rd==0 and alu_we=0.
//   - It wraps modulo 2^CNT_W.
//  WB_RETIRE_CNT_EN undefined:
//   - The port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package rv32_pkg holds:
//    - funct3 load constants LB/LH/LW/LBU/LHU.
//    - XLEN and REG_IDX_W.
//    - wb_state enum {WB_EMPTY, WB_HELD}.
//  - One sub-module load_extend (combinational: rdata, funct3, addr_lo -> XLEN result).
//  - Scoreboard and FSM stay inline.
// TESTING
//  1. Load extension:
//     - rdata=0x8000_80F0, LB, addr_lo=0 -> rd_data=0xFFFF_FFF0.
//     - LBU, addr_lo=0 -> 0x0000_00F0.
//     - LH, addr_lo=2 -> 0xFFFF_8000.
//  2. Collision: alu_valid, rd=3, data=0x11 together with mem_rvalid, rd=4
//     -> cycle+1 writes x4, cycle+2 writes x3=0x11; alu_ready=0 during HELD.
//  3. Scoreboard:
//     - ld_issue rd=5 then rs1_q=5 -> hazard_stall=1 until mem_rvalid rd=5; 0 the next cycle.
//     - ld_issue rd=0 -> never stalls.
//  4. x0: alu_valid rd=0, data=0xDEAD -> reg_write stays 0; retire_count +1 when WB_RETIRE_CNT_EN is defined.
//  5. Reset: rst asserted while HELD with busy[7]=1 -> immediately reg_write=0, alu_ready=1, hazard_stall=0.
//  6. Same-cycle set and clear: ld_issue rd=9 with mem_rvalid rd=9 -> busy[9] stays 1.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths, load funct3 codes and writeback FSM states
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int CNT_W = 64;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic {WB_EMPTY, WB_HELD} wb_state_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the byte/half/word out of an aligned load word and sign/zero extends it
module load_extend
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = rdata[{addr_lo[1], 4'b0000} +: 16];
  // extension by funct3; unknown codes produce zero but the write still happens upstream
  always_comb
    result = (funct3 == F3_LB)  ? {{(XLEN-8){b[7]}}, b} :
             (funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, b} :
             (funct3 == F3_LH)  ? {{(XLEN-16){h[15]}}, h} :
             (funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, h} :
             (funct3 == F3_LW)  ? rdata : '0;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and load responses onto the register file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit
  import rv32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic                 alu_we,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_issue,
  input  logic [REG_IDX_W-1:0] ld_issue_rd,
  input  logic                 mem_rvalid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic [2:0]           mem_funct3,
  input  logic [1:0]           mem_addr_lo,
  input  logic [REG_IDX_W-1:0] rs1_q,
  input  logic [REG_IDX_W-1:0] rs2_q,
  output logic                 hazard_stall,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]     retire_count
`endif
);
  wb_state_e state, state_nx;
  logic                 held_we;
  logic [REG_IDX_W-1:0] held_rd;
  logic [XLEN-1:0]      held_data;
  logic [XLEN-1:0]      ld_data;
  logic [NREG-1:0]      busy, busy_nx;
  logic                 alu_fire, held, out_valid, sel_we;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_data;
  load_extend u_ext (
    .rdata   (mem_rdata),
    .funct3  (mem_funct3),
    .addr_lo (mem_addr_lo),
    .result  (ld_data)
  );
  assign held = (state == WB_HELD);
  assign alu_fire = alu_valid && alu_ready;
  // pending buffer state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WB_EMPTY;
    else state <= state_nx;
  // load collisions park the ALU result; a held entry drains on the first load-free cycle
  always_comb
    state_nx = held ? (mem_rvalid ? WB_HELD : WB_EMPTY) :
               ((alu_fire && mem_rvalid) ? WB_HELD : WB_EMPTY);
  // the ALU is only accepted while the buffer is free
  always_comb
    alu_ready = (state == WB_EMPTY);
  // capture the ALU result displaced by a load response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      held_we   <= 1'b0;
      held_rd   <= '0;
      held_data <= '0;
    end else if (alu_fire && mem_rvalid) begin
      held_we   <= alu_we;
      held_rd   <= alu_rd;
      held_data <= alu_data;
    end
  // source select: load response first, then held ALU result, then live ALU input
  always_comb begin
    out_valid = mem_rvalid | held | alu_fire;
    sel_rd    = mem_rvalid ? mem_rd : held ? held_rd : alu_rd;
    sel_data  = mem_rvalid ? ld_data : held ? held_data : alu_data;
    sel_we    = (mem_rvalid | (held ? held_we : (alu_fire & alu_we))) & (sel_rd != '0);
  end
  // registered write port; suppressed writes present zero index and data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_write <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else begin
      reg_write <= sel_we;
      rd        <= sel_we ? sel_rd : '0;
      rd_data   <= sel_we ? sel_data : '0;
    end
  // scoreboard update: issue sets after response clears so a same-cycle pair stays busy
  always_comb begin
    busy_nx = busy;
    if (mem_rvalid) busy_nx[mem_rd] = 1'b0;
    if (ld_issue) busy_nx[ld_issue_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end
  // scoreboard register
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= busy_nx;
  assign hazard_stall = busy[rs1_q] | busy[rs2_q];
`ifdef WB_RETIRE_CNT_EN
  // one count per output retire cycle, writes or not
  always_ff @(posedge clk or posedge rst)
    if (rst) retire_count <= '0;
    else if (out_valid) retire_count <= retire_count + 1'b1;
`else
  logic unused_ok;
  assign unused_ok = out_valid;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scoreboard bench for writeback_unit
module tb_writeback_unit;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 0, alu_we = 0, ld_issue = 0, mem_rvalid = 0;
  logic [4:0]  alu_rd = 0, ld_issue_rd = 0, mem_rd = 0, rs1_q = 0, rs2_q = 0;
  logic [31:0] alu_data = 0, mem_rdata = 0;
  logic [2:0]  mem_funct3 = 0;
  logic [1:0]  mem_addr_lo = 0;
  logic        alu_ready, hazard_stall, reg_write;
  logic [4:0]  rd;
  logic [31:0] rd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count, rc0;
`endif
  wb_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_we(alu_we),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .mem_rvalid(mem_rvalid), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .hazard_stall(hazard_stall),
    .reg_write(reg_write), .rd(rd), .rd_data(rd_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {59'd0, rd}, 64'hFFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_rd", {59'd0, rd}, {59'd0, e.rd});
        chk("wr_data", {32'd0, rd_data}, {32'd0, e.data});
      end
    end
  endtask
  task automatic mem(input logic [4:0] r, input logic [31:0] d, input logic [2:0] f3,
                     input logic [1:0] lo, input logic [31:0] expd);
    mem_rvalid = 1; mem_rd = r; mem_rdata = d; mem_funct3 = f3; mem_addr_lo = lo;
    exp_q.push_back('{rd: r, data: expd});
  endtask
  task automatic drain(input string tag);
    chk(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
    chk("rst_stall", {63'd0, hazard_stall}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire", retire_count, 64'd0);
`endif
    rst = 0;
    tick();
    // load extension
    mem(5'd1, 32'h8000_80F0, 3'b000, 2'd0, 32'hFFFF_FFF0); tick();
    mem(5'd2, 32'h8000_80F0, 3'b100, 2'd0, 32'h0000_00F0); tick();
    mem(5'd3, 32'h8000_80F0, 3'b001, 2'd2, 32'hFFFF_8000); tick();
    mem(5'd4, 32'h8000_80F0, 3'b010, 2'd1, 32'h8000_80F0); tick();
    mem(5'd5, 32'h8000_80F0, 3'b101, 2'd3, 32'h0000_8000); tick();
    mem(5'd6, 32'h8000_80F0, 3'b000, 2'd1, 32'hFFFF_FF80); tick();
    mem(5'd7, 32'h1234_5678, 3'b101, 2'd0, 32'h0000_5678); tick();
    mem(5'd8, 32'h1234_5678, 3'b011, 2'd0, 32'h0000_0000); tick();
    mem_rvalid = 0; tick();
    drain("ext_drain");
    // collision: load wins, ALU result held and written next
    alu_valid = 1; alu_we = 1; alu_rd = 3; alu_data = 32'h11;
    mem(5'd4, 32'h44, 3'b010, 2'd0, 32'h44);
    exp_q.push_back('{rd: 5'd3, data: 32'h11});
    #1 chk("coll_ready_pre", {63'd0, alu_ready}, 64'd1);
    tick();
    alu_valid = 0; mem_rvalid = 0;
    #1 chk("coll_ready_held", {63'd0, alu_ready}, 64'd0);
    tick();
    chk("coll_ready_after", {63'd0, alu_ready}, 64'd1);
    tick();
    drain("coll_drain");
    // collision followed by another load: held entry waits a further cycle
    alu_valid = 1; alu_we = 1; alu_rd = 12; alu_data = 32'hABCD;
    mem(5'd13, 32'hF00D, 3'b010, 2'd0, 32'hF00D);
    tick();
    alu_valid = 0;
    mem(5'd14, 32'h00C0_0000, 3'b000, 2'd2, 32'hFFFF_FFC0);
    exp_q.push_back('{rd: 5'd12, data: 32'hABCD});
    #1 chk("coll2_ready_held", {63'd0, alu_ready}, 64'd0);
    tick();
    mem_rvalid = 0;
    #1 chk("coll2_ready_still_held", {63'd0, alu_ready}, 64'd0);
    tick(); tick();
    drain("coll2_drain");
    // scoreboard RAW stall
    ld_issue = 1; ld_issue_rd = 5; tick();
    ld_issue = 0; rs1_q = 5;
    #1 chk("sb_stall_set", {63'd0, hazard_stall}, 64'd1);
    tick();
    chk("sb_stall_hold", {63'd0, hazard_stall}, 64'd1);
    mem(5'd5, 32'h55, 3'b010, 2'd0, 32'h55);
    #1 chk("sb_stall_resp_cycle", {63'd0, hazard_stall}, 64'd1);
    tick();
    mem_rvalid = 0;
    #1 chk("sb_stall_clear", {63'd0, hazard_stall}, 64'd0);
    ld_issue = 1; ld_issue_rd = 8; tick();
    ld_issue = 0; rs1_q = 0; rs2_q = 8;
    #1 chk("sb_stall_rs2", {63'd0, hazard_stall}, 64'd1);
    mem(5'd8, 32'h88, 3'b010, 2'd0, 32'h88); tick();
    mem_rvalid = 0;
    #1 chk("sb_stall_rs2_clear", {63'd0, hazard_stall}, 64'd0);
    ld_issue = 1; ld_issue_rd = 0; tick();
    ld_issue = 0; rs1_q = 0; rs2_q = 0;
    #1 chk("sb_x0_nostall", {63'd0, hazard_stall}, 64'd0);
    drain("sb_drain");
    // x0 destination and no-write instruction
`ifdef WB_RETIRE_CNT_EN
    rc0 = retire_count;
`endif
    alu_valid = 1; alu_we = 1; alu_rd = 0; alu_data = 32'hDEAD; tick();
    alu_valid = 0;
    chk("x0_reg_write", {63'd0, reg_write}, 64'd0);
    chk("x0_rd_data", {32'd0, rd_data}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("x0_retire", retire_count, rc0 + 64'd1);
`endif
    alu_valid = 1; alu_we = 0; alu_rd = 7; alu_data = 32'hBEEF; tick();
    alu_valid = 0;
    chk("nowe_reg_write", {63'd0, reg_write}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("nowe_retire", retire_count, rc0 + 64'd2);
`endif
    alu_valid = 1; alu_we = 1; alu_rd = 9; alu_data = 32'h99;
    exp_q.push_back('{rd: 5'd9, data: 32'h99}); tick();
    alu_valid = 0; tick();
    drain("x0_drain");
    // same-cycle set and clear on one index
    ld_issue = 1; ld_issue_rd = 9;
    mem(5'd9, 32'h9, 3'b010, 2'd0, 32'h9); tick();
    ld_issue = 0; mem_rvalid = 0; rs1_q = 9;
    #1 chk("setclr_busy", {63'd0, hazard_stall}, 64'd1);
    mem(5'd9, 32'h90, 3'b010, 2'd0, 32'h90); tick();
    mem_rvalid = 0;
    #1 chk("setclr_cleared", {63'd0, hazard_stall}, 64'd0);
    drain("setclr_drain");
    // reset while HELD with busy[7] set
    ld_issue = 1; ld_issue_rd = 7; tick();
    ld_issue = 0;
    alu_valid = 1; alu_we = 1; alu_rd = 3; alu_data = 32'h33;
    mem(5'd10, 32'hA, 3'b010, 2'd0, 32'hA); tick();
    alu_valid = 0; mem_rvalid = 0; rs1_q = 7;
    #1 chk("pre_rst_ready", {63'd0, alu_ready}, 64'd0);
    chk("pre_rst_stall", {63'd0, hazard_stall}, 64'd1);
    rst = 1;
    #1 chk("mid_rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("mid_rst_ready", {63'd0, alu_ready}, 64'd1);
    chk("mid_rst_stall", {63'd0, hazard_stall}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("mid_rst_retire", retire_count, 64'd0);
`endif
    tick();
    rst = 0;
    tick(); tick();
    chk("post_rst_no_write", {63'd0, reg_write}, 64'd0);
    drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
